trace_record_writer: RTL and testbench

//  Inverse of the trace-file reader: converts binary trace records (opcode, address) into the

---
 rtl/trace_record_writer.sv | 144 ++++++++++++++
 tb/tb_trace_record_writer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_record_writer.sv
// Converts binary trace records (opcode, address) into ASCII lines "<d> <hex>\n",
// one byte per output handshake, with optional leading-zero suppression.
module trace_record_writer #(
    parameter int ADDR_W      = 32,
    parameter bit STRIP_ZEROS = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              err_opcode,
    output logic [CNT_W-1:0]  rec_count
);

    localparam int NIB   = ADDR_W / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [2:0] {
        IDLE,
        OPC,
        SPC,
        HEX,
        NL
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  start_idx;
    logic              capture;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h61 + {4'h0, n - 4'd10};
    endfunction

    function automatic logic [3:0] nibble_at(input logic [ADDR_W-1:0] a,
                                             input logic [IDX_W-1:0]  i);
        logic [ADDR_W-1:0] s;
        s = a >> {i, 2'b00};
        return s[3:0];
    endfunction

    // Index of the most significant nonzero nibble; 0 for a zero address so one "0" prints.
    function automatic logic [IDX_W-1:0] msnz(input logic [ADDR_W-1:0] a);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int k = 0; k < NIB; k++) begin
            if (a[4*k +: 4] != 4'h0) r = IDX_W'(k);
        end
        return r;
    endfunction

    assign start_idx = STRIP_ZEROS ? msnz(in_addr) : IDX_W'(NIB - 1);
    assign capture   = (state == IDLE) && in_valid && (in_opcode <= 4'd9);

    // NOTE: the latched address and digit index carry no reset; they are loaded on every
    // capture and never read in IDLE, so a reset value would only cost enable logic.
    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q <= in_addr;
            idx_q  <= start_idx;
        end else if (state == HEX && out_ready && idx_q != '0) begin
            idx_q  <= idx_q - IDX_W'(1);
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            out_last   <= 1'b0;
            err_opcode <= 1'b0;
            rec_count  <= '0;
        end else begin
            err_opcode <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_opcode > 4'd9) begin
                            err_opcode <= 1'b1;
                        end else begin
                            state     <= OPC;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= 8'h30 + {4'h0, in_opcode};
                            out_last  <= 1'b0;
                        end
                    end
                end
                // Outside IDLE out_valid is always high, so out_ready alone marks a handshake.
                OPC: begin
                    if (out_ready) begin
                        state    <= SPC;
                        out_data <= 8'h20;
                    end
                end
                SPC: begin
                    if (out_ready) begin
                        state    <= HEX;
                        out_data <= hex_char(nibble_at(addr_q, idx_q));
                    end
                end
                HEX: begin
                    if (out_ready) begin
                        if (idx_q == '0) begin
                            state    <= NL;
                            out_data <= 8'h0A;
                            out_last <= 1'b1;
                        end else begin
                            out_data <= hex_char(nibble_at(addr_q, idx_q - IDX_W'(1)));
                        end
                    end
                end
                NL: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        rec_count <= rec_count + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_record_writer.sv
// Directed bench for trace_record_writer: a STRIP_ZEROS=1 instance (CNT_W=16) and a
// STRIP_ZEROS=0 instance with a narrow counter so wrap-around is reachable quickly.
module tb_trace_record_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic        in_valid;
    logic [3:0]  in_opcode;
    logic [31:0] in_addr;
    logic        out_ready;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_last, a_err;
    logic [7:0]  a_out_data;
    logic [15:0] a_cnt;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_last, b_err;
    logic [7:0]  b_out_data;
    logic [3:0]  b_cnt;

    logic        ir, ov, ol, er;
    logic [7:0]  od;
    logic [15:0] cnt;

    assign a_in_valid = in_valid && !sel;
    assign b_in_valid = in_valid && sel;
    assign ir  = sel ? b_in_ready  : a_in_ready;
    assign ov  = sel ? b_out_valid : a_out_valid;
    assign ol  = sel ? b_out_last  : a_out_last;
    assign er  = sel ? b_err       : a_err;
    assign od  = sel ? b_out_data  : a_out_data;
    assign cnt = sel ? {12'h000, b_cnt} : a_cnt;

    trace_record_writer #(.ADDR_W(32), .STRIP_ZEROS(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_opcode(in_opcode), .in_addr(in_addr),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .err_opcode(a_err), .rec_count(a_cnt)
    );

    trace_record_writer #(.ADDR_W(32), .STRIP_ZEROS(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_opcode(in_opcode), .in_addr(in_addr),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .err_opcode(b_err), .rec_count(b_cnt)
    );

    typedef struct {
        bit          use_b;
        logic [3:0]  op;
        logic [31:0] addr;
        bit          rnd;
        string       exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_a    = 0;
    int   exp_b    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic string to_hex(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h ", s[i])};
        return r;
    endfunction

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got [%s], expected [%s]", name, to_hex(act), to_hex(exp));
    endtask

    task automatic add_vec(input bit use_b, input logic [3:0] op, input logic [31:0] addr,
                           input bit rnd, input string exp);
        vec_t v;
        v.use_b = use_b; v.op = op; v.addr = addr; v.rnd = rnd; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Called at a negedge. Offers a record, collects the emitted line and returns the
    // negedge index (1 = first after acceptance) at which the writer is idle again.
    task automatic send_line(input logic [3:0] op, input logic [31:0] addr, input bit rnd,
                             input bit hold, input logic [3:0] nop, input logic [31:0] naddr,
                             output string got, output int idle_n,
                             output bit ok_last, output bit ok_stall, output bit ok_busy);
        int          n, guard;
        bit          done, prev_stall;
        logic [7:0]  prev_d;
        logic        prev_l;
        got = ""; idle_n = -1; ok_last = 1'b1; ok_stall = 1'b1; ok_busy = 1'b1;
        in_valid = 1'b1; in_opcode = op; in_addr = addr;
        guard = 0;
        while (!ir && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!ir) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (hold) begin
            in_opcode = nop; in_addr = naddr;
        end else begin
            in_valid = 1'b0; in_opcode = 4'hf; in_addr = 32'hdeadbeef;
        end
        n = 1; done = 1'b0; prev_stall = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
        while (!done && n < 400) begin
            if (prev_stall && (!ov || od !== prev_d || ol !== prev_l)) ok_stall = 1'b0;
            if (ir || !ov) ok_busy = 1'b0;
            if (ov && (ol !== (od == 8'h0a))) ok_last = 1'b0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ov && out_ready) begin
                got = {got, $sformatf("%c", od)};
                if (ol) done = 1'b1;
            end
            prev_stall = ov && !out_ready; prev_d = od; prev_l = ol;
            @(negedge clk);
            n++;
        end
        out_ready = 1'b1;
        if (!done) begin
            check("line_timeout", 0, 1);
            return;
        end
        idle_n = n;
    endtask

    task automatic check_line_end(input string tag, input string got, input string exp,
                                  input bit rnd, input int idle_n, input bit ok_last,
                                  input bit ok_stall, input bit ok_busy);
        check_str({tag, "_bytes"}, got, exp);
        if (!rnd) check({tag, "_idle_cycle"}, idle_n, exp.len() + 1);
        check({tag, "_in_ready"}, ir, 1'b1);
        check({tag, "_out_valid_low"}, ov, 1'b0);
        check({tag, "_last_only_on_nl"}, ok_last, 1'b1);
        check({tag, "_stall_stable"}, ok_stall, 1'b1);
        check({tag, "_busy_not_ready"}, ok_busy, 1'b1);
        if (sel) exp_b = (exp_b + 1) % 16; else exp_a = (exp_a + 1) % 65536;
        check({tag, "_rec_count"}, cnt, sel ? exp_b : exp_a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        string got;
        int    idle_n, errs, ovs, rc, pop;
        bit    ok_last, ok_stall, ok_busy;
        logic [31:0] paddr;
        logic [3:0]  ops[17];
        logic [31:0] addrs[17];

        reset = 1'b1; sel = 1'b0; in_valid = 1'b0; in_opcode = 4'h0; in_addr = 32'h0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a_in_ready", a_in_ready, 1'b1);
        check("rst_a_out_valid", a_out_valid, 1'b0);
        check("rst_a_out_data", a_out_data, 8'h00);
        check("rst_a_out_last", a_out_last, 1'b0);
        check("rst_a_err", a_err, 1'b0);
        check("rst_a_count", a_cnt, 16'h0);
        check("rst_b_in_ready", b_in_ready, 1'b1);
        check("rst_b_out_valid", b_out_valid, 1'b0);
        check("rst_b_count", b_cnt, 4'h0);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        add_vec(1'b0, 4'd2, 32'h10019d94, 1'b0, "2 10019d94\n");
        add_vec(1'b0, 4'd0, 32'h00000000, 1'b0, "0 0\n");
        add_vec(1'b1, 4'd8, 32'h0000abcd, 1'b0, "8 0000abcd\n");
        add_vec(1'b0, 4'd9, 32'hffffffff, 1'b0, "9 ffffffff\n");
        add_vec(1'b0, 4'd5, 32'h0000000f, 1'b0, "5 f\n");
        add_vec(1'b1, 4'd1, 32'h00000000, 1'b0, "1 00000000\n");
        add_vec(1'b0, 4'd2, 32'h10019d94, 1'b1, "2 10019d94\n");
        add_vec(1'b0, 4'd7, 32'h00a00000, 1'b1, "7 a00000\n");
        add_vec(1'b1, 4'd3, 32'h1234abcd, 1'b1, "3 1234abcd\n");

        for (int i = 0; i < vecs.size(); i++) begin
            sel = vecs[i].use_b;
            send_line(vecs[i].op, vecs[i].addr, vecs[i].rnd, 1'b0, 4'h0, 32'h0,
                      got, idle_n, ok_last, ok_stall, ok_busy);
            check_line_end($sformatf("vec%0d", i), got, vecs[i].exp, vecs[i].rnd, idle_n,
                           ok_last, ok_stall, ok_busy);
        end

        // Illegal opcode: dropped, single-cycle error pulse, no output.
        sel = 1'b0;
        in_valid = 1'b1; in_opcode = 4'd12; in_addr = 32'h1234;
        @(negedge clk);
        in_valid = 1'b0;
        errs = 0; ovs = 0;
        for (int k = 0; k < 6; k++) begin
            errs += int'(er);
            ovs  += int'(ov);
            @(negedge clk);
        end
        check("badop_err_pulses", errs, 1);
        check("badop_no_output", ovs, 0);
        check("badop_rec_count", a_cnt, exp_a);
        check("badop_in_ready", a_in_ready, 1'b1);
        send_line(4'd3, 32'h00000020, 1'b0, 1'b0, 4'h0, 32'h0, got, idle_n, ok_last, ok_stall, ok_busy);
        check_line_end("after_badop", got, "3 20\n", 1'b0, idle_n, ok_last, ok_stall, ok_busy);

        // Reset after four bytes of a line.
        sel = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_opcode = 4'd2; in_addr = 32'h10019d94;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midline_busy", a_out_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", a_out_valid, 1'b0);
        check("midrst_in_ready", a_in_ready, 1'b1);
        check("midrst_count", a_cnt, 16'h0);
        check("midrst_out_last", a_out_last, 1'b0);
        reset = 1'b0;
        exp_a = 0; exp_b = 0;
        ovs = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ovs += int'(a_out_valid) + int'(b_out_valid);
        end
        check("midrst_no_partial", ovs, 0);
        send_line(4'd4, 32'h00000abc, 1'b0, 1'b0, 4'h0, 32'h0, got, idle_n, ok_last, ok_stall, ok_busy);
        check_line_end("after_rst", got, "4 abc\n", 1'b0, idle_n, ok_last, ok_stall, ok_busy);

        // Back-to-back lines on the 4-bit counter instance: 17 lines wrap rec_count to 1.
        sel = 1'b1;
        for (int k = 0; k < 17; k++) begin
            ops[k]   = 4'(k % 10);
            addrs[k] = (32'(k) * 32'h01234567) ^ 32'h5a5a0000;
        end
        for (int k = 0; k < 17; k++) begin
            send_line(ops[k], addrs[k], 1'b0, (k < 16), ops[(k + 1) % 17], addrs[(k + 1) % 17],
                      got, idle_n, ok_last, ok_stall, ok_busy);
            rc = $sscanf(got, "%d %h", pop, paddr);
            check($sformatf("b2b%0d_fields", k), rc, 2);
            check($sformatf("b2b%0d_op", k), pop, ops[k]);
            check($sformatf("b2b%0d_addr", k), paddr, addrs[k]);
            check($sformatf("b2b%0d_len", k), got.len(), 11);
            check($sformatf("b2b%0d_idle", k), idle_n, 12);
            if (k == 15) check("b2b_count_wrap0", b_cnt, 4'h0);
        end
        in_valid = 1'b0;
        check("b2b_count_wrap1", b_cnt, 4'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
